// File: rtl/lights_pkg.sv
// Shared types and default constants for the lights sensor conditioning block.
package lights_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } mv_state_e;

  localparam int         DEF_DEBOUNCE = 4;
  localparam int         DEF_HOLD     = 16;
  localparam int         DEF_SAMPLES  = 3;
  localparam logic [7:0] DEF_DARK_LO  = 8'd40;
  localparam logic [7:0] DEF_DARK_HI  = 8'd60;

  // Debounced channels: bit 0 is the PIR sensor, bit 1 the override button.
  localparam int NUM_CH = 2;
  localparam int CH_PIR = 0;
  localparam int CH_BTN = 1;

endpackage

// File: rtl/lights_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output flips only
// after DEBOUNCE consecutive synchronized samples disagree with it.
module lights_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lights_sensor_cond.sv
// Conditions raw lighting-controller inputs: debounced, hold-extended motion,
// a toggling override, and a hysteretic, sample-qualified darkness flag.
module lights_sensor_cond
  import lights_pkg::*;
#(
  parameter int         DEBOUNCE = DEF_DEBOUNCE,
  parameter int         HOLD     = DEF_HOLD,
  parameter int         SAMPLES  = DEF_SAMPLES,
  parameter logic [7:0] DARK_LO  = DEF_DARK_LO,
  parameter logic [7:0] DARK_HI  = DEF_DARK_HI
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lux_val,
  input  logic [7:0] lux,
  input  logic       pir,
  input  logic       force_btn,
  output logic       dark,
  output logic       movement,
  output logic       force_on
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int SW = $clog2(SAMPLES + 1);

  logic [NUM_CH-1:0] raw, deb;
  assign raw = {force_btn, pir};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lights_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .level (deb[g])
    );
  end

  // Movement FSM: hold count restarts on every cycle the debounced PIR is high.
  mv_state_e     state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    case (state)
      ST_IDLE: if (deb[CH_PIR]) begin
        state_nx = ST_HOLD;
        hold_nx  = HW'(HOLD);
      end
      ST_HOLD: begin
        if (deb[CH_PIR])                hold_nx  = HW'(HOLD);
        else if (hold_cnt == HW'(1))    state_nx = ST_IDLE;
        else                            hold_nx  = hold_cnt - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb movement = (state == ST_HOLD);

  // Override toggles once per debounced press, one cycle after the rise.
  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q    <= 1'b0;
      force_on <= 1'b0;
    end else begin
      btn_q <= deb[CH_BTN];
      if (deb[CH_BTN] && !btn_q) force_on <= ~force_on;
    end
  end

  // Darkness hysteresis: a run of SAMPLES same-side samples moves the flag;
  // mid-band samples break both runs, invalid cycles are ignored.
  logic [SW-1:0] dark_cnt, light_cnt, dark_cnt_nx, light_cnt_nx;
  logic          dark_nx;

  always_comb begin
    dark_cnt_nx  = dark_cnt;
    light_cnt_nx = light_cnt;
    dark_nx      = dark;
    if (lux_val) begin
      if (lux < DARK_LO) begin
        dark_cnt_nx  = (dark_cnt == SW'(SAMPLES)) ? dark_cnt : dark_cnt + 1'b1;
        light_cnt_nx = '0;
        if (dark_cnt_nx == SW'(SAMPLES)) dark_nx = 1'b1;
      end else if (lux > DARK_HI) begin
        light_cnt_nx = (light_cnt == SW'(SAMPLES)) ? light_cnt : light_cnt + 1'b1;
        dark_cnt_nx  = '0;
        if (light_cnt_nx == SW'(SAMPLES)) dark_nx = 1'b0;
      end else begin
        dark_cnt_nx  = '0;
        light_cnt_nx = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dark_cnt  <= '0;
      light_cnt <= '0;
      dark      <= 1'b0;
    end else begin
      dark_cnt  <= dark_cnt_nx;
      light_cnt <= light_cnt_nx;
      dark      <= dark_nx;
    end
  end

endmodule

// File: tb/tb_lights_sensor_cond.sv
// Bench for lights_sensor_cond: lux vector table, directed multi-cycle
// sequences, and a randomized run against a history-based reference model.
module tb_lights_sensor_cond;

  localparam int         D  = 4;
  localparam int         H  = 16;
  localparam int         S  = 3;
  localparam logic [7:0] LO = 8'd40;
  localparam logic [7:0] HI = 8'd60;
  localparam int         HSZ = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lux_val = 1'b0;
  logic [7:0] lux = 8'd0;
  logic       pir = 1'b0;
  logic       force_btn = 1'b0;
  logic       dark, movement, force_on;

  lights_sensor_cond #(
    .DEBOUNCE(D), .HOLD(H), .SAMPLES(S), .DARK_LO(LO), .DARK_HI(HI)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lux_val   (lux_val),
    .lux       (lux),
    .pir       (pir),
    .force_btn (force_btn),
    .dark      (dark),
    .movement  (movement),
    .force_on  (force_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the synchronized-sample history per channel, the
  // cycle of the last debounced PIR high, and the last S lux categories.
  int  cyc = 0;
  bit  m_s1[2], m_s2[2], m_deb[2];
  int  m_flip[2];
  bit  s2h[2][HSZ];
  int  m_last_hi = -100000;
  bit  m_debq, m_force, m_dark, m_mov;
  int  lq[$];

  task automatic model_step();
    bit dp[2];
    bit all_diff;
    dp[0] = m_deb[0];
    dp[1] = m_deb[1];
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_flip[i] = cyc;
      end
      m_last_hi = -100000;
      m_debq = 0; m_force = 0; m_dark = 0;
      lq.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        s2h[i][cyc % HSZ] = m_s2[i];
        if (cyc - m_flip[i] >= D) begin
          all_diff = 1;
          for (int k = cyc - D + 1; k <= cyc; k++)
            if (s2h[i][k % HSZ] == dp[i]) all_diff = 0;
          if (all_diff) begin
            m_deb[i]  = ~dp[i];
            m_flip[i] = cyc;
          end
        end
        m_s2[i] = m_s1[i];
      end
      m_s1[0] = pir;
      m_s1[1] = force_btn;
      if (dp[0]) m_last_hi = cyc;
      if (dp[1] && !m_debq) m_force = ~m_force;
      m_debq = dp[1];
      if (lux_val) begin
        lq.push_back(lux < LO ? 0 : (lux > HI ? 2 : 1));
        if (lq.size() > S) void'(lq.pop_front());
        if (lq.size() == S) begin
          if (lq.sum() == 0) m_dark = 1;
          else if (lq.sum() == 2 * S) m_dark = 0;
        end
      end
    end
    m_mov = (cyc - m_last_hi) < H;
    cyc++;
  endtask

  task automatic tick(input bit r, input bit lv, input logic [7:0] lx,
                      input bit p, input bit b);
    reset = r; lux_val = lv; lux = lx; pir = p; force_btn = b;
    @(posedge clk);
    model_step();
    #1;
    check("model_dark", dark, m_dark);
    check("model_movement", movement, m_mov);
    check("model_force_on", force_on, m_force);
    @(negedge clk);
  endtask

  typedef struct {
    bit         lv;
    logic [7:0] lx;
    bit         exp_dark;
  } lux_vec_t;

  lux_vec_t tbl[19];

  initial begin
    tbl[0]  = '{1, 8'd30, 0};  tbl[1]  = '{1, 8'd30, 0};
    tbl[2]  = '{0, 8'd0,  0};  tbl[3]  = '{1, 8'd30, 1};
    tbl[4]  = '{1, 8'd70, 1};  tbl[5]  = '{1, 8'd50, 1};
    tbl[6]  = '{1, 8'd70, 1};  tbl[7]  = '{1, 8'd70, 1};
    tbl[8]  = '{1, 8'd70, 0};  tbl[9]  = '{1, 8'd39, 0};
    tbl[10] = '{1, 8'd40, 0};  tbl[11] = '{1, 8'd39, 0};
    tbl[12] = '{1, 8'd39, 0};  tbl[13] = '{1, 8'd39, 1};
    tbl[14] = '{1, 8'd60, 1};  tbl[15] = '{1, 8'd61, 1};
    tbl[16] = '{1, 8'd61, 1};  tbl[17] = '{1, 8'd61, 0};
    tbl[18] = '{0, 8'd0,  0};

    @(negedge clk);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("reset_dark", dark, 1'b0);
    check("reset_movement", movement, 1'b0);
    check("reset_force_on", force_on, 1'b0);

    // Lux hysteresis table, including gaps and the threshold boundaries.
    foreach (tbl[i]) begin
      tick(0, tbl[i].lv, tbl[i].lx, 0, 0);
      check($sformatf("lux_tbl[%0d]", i), dark, tbl[i].exp_dark);
    end

    // PIR held high: movement rises after edge 7; after release, falls after edge 22.
    tick(1, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) begin
      tick(0, 0, 0, 1, 0);
      check($sformatf("pir_rise_e%0d", e), movement, e >= 7);
    end
    for (int e = 1; e <= 25; e++) begin
      tick(0, 0, 0, 0, 0);
      check($sformatf("pir_fall_e%0d", e), movement, e <= 21);
    end

    // Retrigger: re-high at edge 10 of the low phase keeps movement asserted.
    tick(1, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) tick(0, 0, 0, 1, 0);
    for (int e = 1; e <= 19; e++) begin
      tick(0, 0, 0, (e >= 10), 0);
      check($sformatf("retrig_e%0d", e), movement, 1'b1);
    end
    for (int e = 1; e <= 30; e++) tick(0, 0, 0, 0, 0);

    // Short PIR pulse never qualifies.
    tick(1, 0, 0, 0, 0);
    for (int e = 1; e <= 43; e++) begin
      tick(0, 0, 0, (e <= 3), 0);
      check($sformatf("pir_short_e%0d", e), movement, 1'b0);
    end

    // Override: toggles after edge 7 of each press, release has no effect.
    tick(1, 0, 0, 0, 0);
    for (int e = 1; e <= 10; e++) begin
      tick(0, 0, 0, 0, 1);
      check($sformatf("btn_press1_e%0d", e), force_on, e >= 7);
    end
    for (int e = 1; e <= 10; e++) begin
      tick(0, 0, 0, 0, 0);
      check($sformatf("btn_release_e%0d", e), force_on, 1'b1);
    end
    for (int e = 1; e <= 10; e++) begin
      tick(0, 0, 0, 0, 1);
      check($sformatf("btn_press2_e%0d", e), force_on, e < 7);
    end

    // Reset with all outputs high, then fresh qualification afterwards.
    tick(1, 0, 0, 0, 0);
    for (int e = 1; e <= 10; e++) tick(0, 1, 8'd30, 1, 1);
    check("pre_rst_dark", dark, 1'b1);
    check("pre_rst_movement", movement, 1'b1);
    check("pre_rst_force_on", force_on, 1'b1);
    tick(1, 1, 8'd30, 1, 1);
    check("mid_rst_dark", dark, 1'b0);
    check("mid_rst_movement", movement, 1'b0);
    check("mid_rst_force_on", force_on, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      tick(0, 1, 8'd30, 1, 1);
      check($sformatf("post_rst_movement_e%0d", e), movement, e >= 7);
      check($sformatf("post_rst_force_e%0d", e), force_on, e >= 7);
      check($sformatf("post_rst_dark_e%0d", e), dark, e >= 3);
    end

    // Randomized run: slowly-changing sensor levels, noisy lux around thresholds.
    begin
      bit p = 0, b = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(11, 0) == 0) p = ~p;
        if ($urandom_range(14, 0) == 0) b = ~b;
        tick(($urandom_range(299, 0) == 0), $urandom_range(1, 0),
             8'($urandom_range(75, 25)), p, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lights_sensor_cond.md
LIGHTS_SENSOR_COND -- requirements
Module: lights_sensor_cond

Interface
REQ-001 Parameter DEBOUNCE, default 4, consecutive synchronized cycles needed to accept a level change on pir or force_btn (legal range >=1).
REQ-002 Parameter HOLD, default 16, cycles movement stays asserted after the debounced pir falls (legal range >=1).
REQ-003 Parameter SAMPLES, default 3, consecutive qualifying valid lux samples needed to change dark (legal range >=1).
REQ-004 Parameter DARK_LO, default 8'd40, dark-entry threshold (strictly below), DARK_LO < DARK_HI.
REQ-005 Parameter DARK_HI, default 8'd60, dark-exit threshold (strictly above).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 lux_val  input  1  lux carries a valid ambient-light sample this cycle.
REQ-009 lux  input  8  unsigned ambient-light sample.
REQ-010 pir  input  1  raw asynchronous motion-sensor level.
REQ-011 force_btn  input  1  raw asynchronous override push-button level.
REQ-012 dark  output  1  registered, conditioned darkness flag.
REQ-013 movement  output  1  registered, debounced and hold-extended motion flag.
REQ-014 force_on  output  1  registered override state; toggles on each debounced button press.

Function
REQ-015 Each of pir and force_btn SHALL pass through a 2-flop synchronizer, then a debouncer whose level output flips only after DEBOUNCE consecutive edges where the synchronized value differs from the current level; any agreeing cycle clears the count.
REQ-016 Debounced level SHALL therefore change on edge DEBOUNCE+2, with edge 1 being the first edge sampling the new raw value held stable.
REQ-017 Movement FSM SHALL have states IDLE and HOLD; movement = (state == HOLD).
REQ-018 IDLE -> HOLD on an edge where debounced pir = 1, loading hold count with HOLD.
REQ-019 In HOLD, debounced pir = 1 SHALL reload count to HOLD (retrigger); debounced pir = 0 with count == 1 SHALL go to IDLE; otherwise count decrements.
REQ-020 A pir pulse shorter than DEBOUNCE synchronized cycles SHALL never assert movement.
REQ-021 force_on SHALL toggle on the edge after the debounced force_btn rises; release SHALL not toggle.
REQ-022 A valid sample with lux < DARK_LO SHALL increment the dark-qualify count and clear the light-qualify count; lux > DARK_HI the reverse; DARK_LO <= lux <= DARK_HI SHALL clear both.
REQ-023 dark SHALL set on the edge accepting the SAMPLES-th consecutive lux < DARK_LO sample, and clear on the edge accepting the SAMPLES-th consecutive lux > DARK_HI sample; counts saturate at SAMPLES.
REQ-024 lux_val = 0 cycles SHALL leave both qualify counts and dark unchanged (gaps do not break a run).
REQ-025 Samples agreeing with the current dark value (e.g. dark low while dark=1) SHALL still update counts but not change dark.

Reset
REQ-026 Reset SHALL clear synchronizer flops, debounce levels and counts, qualify counts, hold count, FSM to IDLE, and drive dark=0, movement=0, force_on=0 the cycle after reset is sampled high.
REQ-027 Reset asserted mid-HOLD or mid-debounce SHALL discard the operation; no output glitches high during or after reset.

Structure
REQ-028 Package lights_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-029 Sub-module lights_debounce (synchronizer + debouncer, DEBOUNCE parameter) SHALL be instantiated twice, for pir and force_btn.

Verification (defaults)
REQ-030 pir high from edge 1 held -> debounced rises edge 6, movement rises after edge 7.
REQ-031 pir long-high then low from edge 1 -> movement falls after edge 22; pir re-high at edge 10 for 10 cycles -> movement stays high (retrigger).
REQ-032 pir high for 3 cycles only -> movement stays 0 for 40 cycles.
REQ-033 lux_val pulses with lux 30,30,idle,30 -> dark=1 after the third valid sample; then 70,50,70,70,70 -> dark clears only after the final 70.
REQ-034 force_btn press held 10 cycles -> force_on=1 after edge 7, unchanged on release; second press -> 0.
REQ-035 Reset asserted while movement=1, dark=1, force_on=1 -> all three 0 the next cycle; movement re-asserts only via a fresh DEBOUNCE qualification.
